// File: rtl/register_file_16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// register_file_16 : 8 x DATA_W register file with two read ports and one debug read port
// Revision 1.0
// ============================================================================
module register_file_16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** ADDR_W;

  // R0 has no storage; it is supplied as a constant in the read view.
  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [DATA_W-1:0] regs_d [1:NREG-1];
  logic [DATA_W-1:0] rd_view [0:NREG-1];
  logic              wr_live;
  logic              fwd_rs;
  logic              fwd_rt;

  assign wr_live = wr_en && (wr_addr != '0);

  always_comb begin
    for (int i = 1; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_live && (wr_addr == ADDR_W'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rd_view[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      rd_view[i] = regs_q[i];
    end
  end

  // Forwarding is suppressed under reset so every port reads zero while reset_n is low.
  assign fwd_rs = (BYPASS != 0) && reset_n && wr_live && (wr_addr == rs_addr);
  assign fwd_rt = (BYPASS != 0) && reset_n && wr_live && (wr_addr == rt_addr);

  assign rs_data  = fwd_rs ? wr_data : rd_view[rs_addr];
  assign rt_data  = fwd_rt ? wr_data : rd_view[rt_addr];
  assign dbg_data = rd_view[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_register_file_16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_register_file_16 : scoreboard bench for register_file_16, BYPASS=0 and BYPASS=1 side by side
// Revision 1.0
// ============================================================================
module tb_register_file_16;

  logic        clk;
  logic        reset_n;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  dbg_addr;
  logic [15:0] rs0, rt0, dbg0;
  logic [15:0] rs1, rt1, dbg1;

  logic [15:0] sb [$];
  logic [15:0] model [0:7];
  int          n_checks;
  int          n_pass;

  register_file_16 #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs0), .rt_data(rt0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  register_file_16 #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs1), .rt_data(rt1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a != 3'd0) model[a] = d;
  endtask

  task automatic test_reset;
    logic [15:0] exp;
    reset_n = 1'b0;
    #1;
    for (int a = 0; a < 8; a++) begin
      rs_addr = 3'(a); rt_addr = 3'(a); dbg_addr = 3'(a);
      sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0000);
      #0.5;
      exp = sb.pop_front(); n_checks++;
      if (rs0 !== exp) $display("FAIL reset_init_rs a=%0d got %h want %h", a, rs0, exp); else n_pass++;
      exp = sb.pop_front(); n_checks++;
      if (rt0 !== exp) $display("FAIL reset_init_rt a=%0d got %h want %h", a, rt0, exp); else n_pass++;
      exp = sb.pop_front(); n_checks++;
      if (dbg0 !== exp) $display("FAIL reset_init_dbg a=%0d got %h want %h", a, dbg0, exp); else n_pass++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 1; a < 8; a++) do_write(3'(a), 16'hFFFF);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      sb.push_back(model[a]);
      #0.5;
      exp = sb.pop_front(); n_checks++;
      if (dbg0 !== exp) $display("FAIL fill_dbg a=%0d got %h want %h", a, dbg0, exp); else n_pass++;
    end
    // Drop reset mid-cycle; every read must clear before the next clock edge.
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rs_addr = 3'(a); rt_addr = 3'(a); dbg_addr = 3'(a);
      sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0000);
      #0.4;
      exp = sb.pop_front(); n_checks++;
      if (rs0 !== exp) $display("FAIL async_reset_rs a=%0d got %h want %h", a, rs0, exp); else n_pass++;
      exp = sb.pop_front(); n_checks++;
      if (rt1 !== exp) $display("FAIL async_reset_rt a=%0d got %h want %h", a, rt1, exp); else n_pass++;
      exp = sb.pop_front(); n_checks++;
      if (dbg1 !== exp) $display("FAIL async_reset_dbg a=%0d got %h want %h", a, dbg1, exp); else n_pass++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) model[a] = 16'h0000;
  endtask

  task automatic test_basic;
    logic [15:0] exp;
    do_write(3'd3, 16'h1234);
    do_write(3'd5, 16'hABCD);
    rs_addr = 3'd3; rt_addr = 3'd5;
    sb.push_back(16'h1234); sb.push_back(16'hABCD);
    sb.push_back(16'h1234); sb.push_back(16'hABCD);
    #1;
    exp = sb.pop_front(); n_checks++;
    if (rs0 !== exp) $display("FAIL basic_rs0 got %h want %h", rs0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rt0 !== exp) $display("FAIL basic_rt0 got %h want %h", rt0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rs1 !== exp) $display("FAIL basic_rs1 got %h want %h", rs1, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rt1 !== exp) $display("FAIL basic_rt1 got %h want %h", rt1, exp); else n_pass++;
    // Dual-port read of one address
    rt_addr = 3'd3;
    sb.push_back(16'h1234);
    #1;
    exp = sb.pop_front(); n_checks++;
    if (rt0 !== exp) $display("FAIL dual_same_rt got %h want %h", rt0, exp); else n_pass++;
  endtask

  task automatic test_r0;
    logic [15:0] exp;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF;
    rs_addr = 3'd0; rt_addr = 3'd0; dbg_addr = 3'd0;
    for (int k = 0; k < 4; k++) sb.push_back(16'h0000);
    #1;
    exp = sb.pop_front(); n_checks++;
    if (rs0 !== exp) $display("FAIL r0_write_rs0 got %h want %h", rs0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rt0 !== exp) $display("FAIL r0_write_rt0 got %h want %h", rt0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rs1 !== exp) $display("FAIL r0_write_rs1 got %h want %h", rs1, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rt1 !== exp) $display("FAIL r0_write_rt1 got %h want %h", rt1, exp); else n_pass++;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) sb.push_back(16'h0000);
    #1;
    exp = sb.pop_front(); n_checks++;
    if (rs0 !== exp) $display("FAIL r0_after_rs0 got %h want %h", rs0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rs1 !== exp) $display("FAIL r0_after_rs1 got %h want %h", rs1, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (dbg1 !== exp) $display("FAIL r0_after_dbg1 got %h want %h", dbg1, exp); else n_pass++;
  endtask

  task automatic test_we_gating;
    logic [15:0] exp;
    do_write(3'd2, 16'h00F0);
    rs_addr = 3'd2; dbg_addr = 3'd2;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      wr_en = 1'b0; wr_addr = 3'd2; wr_data = 16'h0F0F;
      sb.push_back(16'h00F0);
      #1;
      exp = sb.pop_front(); n_checks++;
      if (rs1 !== exp) $display("FAIL we_gate_nofwd e=%0d got %h want %h", e, rs1, exp); else n_pass++;
    end
    @(posedge clk);
    #1;
    sb.push_back(16'h00F0); sb.push_back(16'h00F0);
    exp = sb.pop_front(); n_checks++;
    if (dbg0 !== exp) $display("FAIL we_gate_dbg0 got %h want %h", dbg0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rs0 !== exp) $display("FAIL we_gate_rs0 got %h want %h", rs0, exp); else n_pass++;
  endtask

  task automatic test_same_cycle;
    logic [15:0] exp;
    do_write(3'd4, 16'h1111);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h2222;
    rs_addr = 3'd4; rt_addr = 3'd4; dbg_addr = 3'd4;
    sb.push_back(16'h1111); sb.push_back(16'h1111);
    sb.push_back(16'h2222); sb.push_back(16'h2222); sb.push_back(16'h1111);
    #1;
    exp = sb.pop_front(); n_checks++;
    if (rs0 !== exp) $display("FAIL rw_pre_rs0 got %h want %h", rs0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rt0 !== exp) $display("FAIL rw_pre_rt0 got %h want %h", rt0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rs1 !== exp) $display("FAIL rw_pre_rs1 got %h want %h", rs1, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rt1 !== exp) $display("FAIL rw_pre_rt1 got %h want %h", rt1, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (dbg1 !== exp) $display("FAIL rw_pre_dbg1 got %h want %h", dbg1, exp); else n_pass++;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[4] = 16'h2222;
    sb.push_back(16'h2222); sb.push_back(16'h2222);
    #1;
    exp = sb.pop_front(); n_checks++;
    if (rs0 !== exp) $display("FAIL rw_post_rs0 got %h want %h", rs0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rs1 !== exp) $display("FAIL rw_post_rs1 got %h want %h", rs1, exp); else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] exp;
    logic [15:0] fwd;
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 9) < 7);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 16'($urandom);
      rs_addr = 3'($urandom_range(0, 7));
      rt_addr = 3'($urandom_range(0, 7));
      fwd = (wr_en && wr_addr != 3'd0 && wr_addr == rs_addr) ? wr_data : model[rs_addr];
      sb.push_back(model[rs_addr]); sb.push_back(model[rt_addr]); sb.push_back(fwd);
      #1;
      exp = sb.pop_front(); n_checks++;
      if (rs0 !== exp) $display("FAIL rand_rs0 it=%0d got %h want %h", it, rs0, exp); else n_pass++;
      exp = sb.pop_front(); n_checks++;
      if (rt0 !== exp) $display("FAIL rand_rt0 it=%0d got %h want %h", it, rt0, exp); else n_pass++;
      exp = sb.pop_front(); n_checks++;
      if (rs1 !== exp) $display("FAIL rand_rs1 it=%0d got %h want %h", it, rs1, exp); else n_pass++;
      @(posedge clk);
      if (wr_en && wr_addr != 3'd0) model[wr_addr] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset_collision;
    logic [15:0] exp;
    do_write(3'd6, 16'h0A0A);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5555;
    rs_addr = 3'd6; dbg_addr = 3'd6;
    reset_n = 1'b0;
    sb.push_back(16'h0000); sb.push_back(16'h0000);
    #1;
    exp = sb.pop_front(); n_checks++;
    if (rs0 !== exp) $display("FAIL coll_rs0 got %h want %h", rs0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (rs1 !== exp) $display("FAIL coll_rs1_nofwd got %h want %h", rs1, exp); else n_pass++;
    @(posedge clk);
    #1;
    @(negedge clk);
    wr_en = 1'b0;
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) model[a] = 16'h0000;
    sb.push_back(16'h0000); sb.push_back(16'h0000);
    #1;
    exp = sb.pop_front(); n_checks++;
    if (dbg0 !== exp) $display("FAIL coll_after_dbg0 got %h want %h", dbg0, exp); else n_pass++;
    exp = sb.pop_front(); n_checks++;
    if (dbg1 !== exp) $display("FAIL coll_after_dbg1 got %h want %h", dbg1, exp); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 16'h0000;
    rs_addr  = 3'd0;
    rt_addr  = 3'd0;
    dbg_addr = 3'd0;
    for (int a = 0; a < 8; a++) model[a] = 16'h0000;

    test_reset();
    test_basic();
    test_r0();
    test_we_gating();
    test_same_cycle();
    test_random();
    test_reset_collision();

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
